// File: rtl/sdram_arbit_pkg.sv
// sdram_arbit_pkg: shared SDRAM controller constants and arbiter state codes.
package sdram_arbit_pkg;
   localparam logic [3:0] CMD_NOP = 4'b0111;
   typedef enum logic [2:0] {
      INIT  = 3'b000,
      ARBIT = 3'b001,
      AREF  = 3'b011,
      WRITE = 3'b010,
      READ  = 3'b110
   } arb_state_e;
endpackage

// File: rtl/sdram_arbit.sv
// sdram_arbit: grants the SDRAM command/address/DQ bus to init, refresh, write or read.
// Refresh has priority; write and read alternate when both are pending.
module sdram_arbit
   import sdram_arbit_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 13,
   parameter int BANK_W = 2
) (
   input  logic              arb_clk,
   input  logic              arb_rst,
   input  logic              init_end,
   input  logic [3:0]        init_cmd,
   input  logic [BANK_W-1:0] init_bank,
   input  logic [ADDR_W-1:0] init_addr,
   input  logic              aref_req,
   input  logic              aref_end,
   output logic              aref_en,
   input  logic [3:0]        aref_cmd,
   input  logic [BANK_W-1:0] aref_bank,
   input  logic [ADDR_W-1:0] aref_addr,
   input  logic              wr_req,
   input  logic              wr_end,
   output logic              wr_en,
   input  logic              wr_sdram_en,
   input  logic [3:0]        wr_sdram_cmd,
   input  logic [BANK_W-1:0] wr_sdram_bank,
   input  logic [ADDR_W-1:0] wr_sdram_addr,
   input  logic [DATA_W-1:0] wr_sdram_data,
   input  logic              rd_req,
   input  logic              rd_end,
   output logic              rd_en,
   input  logic [3:0]        rd_sdram_cmd,
   input  logic [BANK_W-1:0] rd_sdram_bank,
   input  logic [ADDR_W-1:0] rd_sdram_addr,
   output logic              sdram_cke,
   output logic              sdram_cs_n,
   output logic              sdram_ras_n,
   output logic              sdram_cas_n,
   output logic              sdram_we_n,
   output logic [BANK_W-1:0] sdram_bank,
   output logic [ADDR_W-1:0] sdram_addr,
   inout  wire  [DATA_W-1:0] sdram_dq
);
   arb_state_e r_state, w_next;
   logic r_aref_en, r_wr_en, r_rd_en, r_last_wr;
   logic [3:0] w_cmd;
   logic [BANK_W-1:0] w_bank;
   logic [ADDR_W-1:0] w_addr;

   always_comb begin
      w_next = r_state;
      case (r_state)
         INIT:  w_next = init_end ? ARBIT : INIT;
         ARBIT: w_next = aref_req ? AREF :
                         (wr_req && rd_req) ? (r_last_wr ? READ : WRITE) :
                         wr_req ? WRITE : rd_req ? READ : ARBIT;
         AREF:  w_next = aref_end ? ARBIT : AREF;
         WRITE: w_next = wr_end ? ARBIT : WRITE;
         READ:  w_next = rd_end ? ARBIT : READ;
         default: w_next = INIT;
      endcase
   end

   // pins are muxed from the registered state, so sub-module commands pass with no added latency
   always_comb begin
      w_cmd  = CMD_NOP;
      w_bank = '0;
      w_addr = '0;
      case (r_state)
         INIT:  {w_cmd, w_bank, w_addr} = {init_cmd, init_bank, init_addr};
         AREF:  {w_cmd, w_bank, w_addr} = {aref_cmd, aref_bank, aref_addr};
         WRITE: {w_cmd, w_bank, w_addr} = {wr_sdram_cmd, wr_sdram_bank, wr_sdram_addr};
         READ:  {w_cmd, w_bank, w_addr} = {rd_sdram_cmd, rd_sdram_bank, rd_sdram_addr};
         default: ;
      endcase
   end

   always_ff @(posedge arb_clk or posedge arb_rst) begin
      if (arb_rst) begin
         r_state   <= INIT;
         r_aref_en <= 1'b0;
         r_wr_en   <= 1'b0;
         r_rd_en   <= 1'b0;
         r_last_wr <= 1'b0;
      end else begin
         r_state   <= w_next;
         r_aref_en <= w_next == AREF;
         r_wr_en   <= w_next == WRITE;
         r_rd_en   <= w_next == READ;
         if (r_state == WRITE && wr_end)
            r_last_wr <= 1'b1;
         else if (r_state == READ && rd_end)
            r_last_wr <= 1'b0;
      end
   end

   assign aref_en   = r_aref_en;
   assign wr_en     = r_wr_en;
   assign rd_en     = r_rd_en;
   assign sdram_cke = 1'b1;
   assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = w_cmd;
   assign sdram_bank = w_bank;
   assign sdram_addr = w_addr;
   assign sdram_dq   = (r_state == WRITE && wr_sdram_en) ? wr_sdram_data : 'z;
endmodule

// File: tb/tb_sdram_arbit.sv
// tb_sdram_arbit: directed stimulus for sdram_arbit; grants are checked by a scoreboard monitor.
module tb_sdram_arbit;
   import sdram_arbit_pkg::*;
   localparam logic [3:0]  C_INIT = 4'b0010, C_AREF = 4'b0001, C_WR = 4'b0100, C_RD = 4'b0101;
   localparam logic [1:0]  B_INIT = 2'd0, B_AREF = 2'd1, B_WR = 2'd2, B_RD = 2'd3;
   localparam logic [12:0] A_INIT = 13'h0400, A_AREF = 13'h0111, A_WR = 13'h0222, A_RD = 13'h0333;

   logic clk = 0, rst = 0, init_end = 0;
   logic aref_req = 0, aref_end = 0, wr_req = 0, wr_end = 0, rd_req = 0, rd_end = 0;
   logic wr_sdram_en = 0;
   logic [15:0] wr_data = 0;
   logic aref_en, wr_en, rd_en, cke, cs_n, ras_n, cas_n, we_n;
   logic [1:0] bank;
   logic [12:0] addr;
   wire [15:0] dq;
   int checks = 0, failures = 0;
   int q[$];
   logic [2:0] prev_en = 0;
   int got, expv;

   for (genvar i = 0; i < 16; i++) begin : g_pu
      pullup (dq[i]);
   end

   sdram_arbit #(.DATA_W(16), .ADDR_W(13), .BANK_W(2)) dut (
      .arb_clk(clk), .arb_rst(rst), .init_end(init_end),
      .init_cmd(C_INIT), .init_bank(B_INIT), .init_addr(A_INIT),
      .aref_req(aref_req), .aref_end(aref_end), .aref_en(aref_en),
      .aref_cmd(C_AREF), .aref_bank(B_AREF), .aref_addr(A_AREF),
      .wr_req(wr_req), .wr_end(wr_end), .wr_en(wr_en), .wr_sdram_en(wr_sdram_en),
      .wr_sdram_cmd(C_WR), .wr_sdram_bank(B_WR), .wr_sdram_addr(A_WR), .wr_sdram_data(wr_data),
      .rd_req(rd_req), .rd_end(rd_end), .rd_en(rd_en),
      .rd_sdram_cmd(C_RD), .rd_sdram_bank(B_RD), .rd_sdram_addr(A_RD),
      .sdram_cke(cke), .sdram_cs_n(cs_n), .sdram_ras_n(ras_n), .sdram_cas_n(cas_n),
      .sdram_we_n(we_n), .sdram_bank(bank), .sdram_addr(addr), .sdram_dq(dq)
   );

   always #5 clk = ~clk;

   // grant scoreboard: 1 = refresh, 2 = write, 3 = read
   always @(negedge clk) begin
      if (({aref_en, wr_en, rd_en} & ~prev_en) != 3'b000) begin
         got = (aref_en && !prev_en[2]) ? 1 : (wr_en && !prev_en[1]) ? 2 : 3;
         checks++;
         if (q.size() == 0) begin
            failures++;
            $display("FAIL sb_grant: got grant %0d, expected none", got);
         end else begin
            expv = q.pop_front();
            if (got != expv || $countones({aref_en, wr_en, rd_en}) != 1) begin
               failures++;
               $display("FAIL sb_grant: got grant %0d (en=%b), expected %0d", got, {aref_en, wr_en, rd_en}, expv);
            end
         end
      end
      prev_en = {aref_en, wr_en, rd_en};
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [18:0] bus_of(input int k);
      return k == 0 ? {C_INIT, B_INIT, A_INIT} : k == 1 ? {C_AREF, B_AREF, A_AREF} :
             k == 2 ? {C_WR, B_WR, A_WR} : k == 3 ? {C_RD, B_RD, A_RD} : {CMD_NOP, 2'b00, 13'h0};
   endfunction

   function automatic logic en_of(input int k);
      return k == 1 ? aref_en : k == 2 ? wr_en : rd_en;
   endfunction

   task automatic chk_pins(input string name, input int k);
      chk(name, {13'h0, cs_n, ras_n, cas_n, we_n, bank, addr}, {13'h0, bus_of(k)});
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_end(input int k, input logic v);
      if (k == 1) aref_end = v;
      else if (k == 2) wr_end = v;
      else rd_end = v;
   endtask

   task automatic wait_grant(input int k, input int exp_cyc);
      int n = 0;
      do begin
         tick();
         n++;
      end while (!en_of(k) && n < 10);
      chk("grant_latency", n, exp_cyc);
   endtask

   // drive a granted sub-module for len cycles, then pulse its end
   task automatic run_txn(input int k, input int len, input int aref_at);
      for (int i = 0; i < len; i++) begin
         wr_sdram_en = 1;
         wr_data = 16'(i);
         if (i == aref_at) aref_req = 1;
         #1;
         chk_pins("txn_pins", k);
         chk("txn_dq", dq, k == 2 ? 16'(i) : 16'hFFFF);
         if (aref_req && k != 1) chk("no_preempt", aref_en, 0);
         tick();
      end
      wr_sdram_en = 0;
      set_end(k, 1);
      #1;
      chk_pins("end_pins", k);
      chk("end_dq", dq, 16'hFFFF);
      tick();
      set_end(k, 0);
      #1;
      chk("end_grant", {aref_en, wr_en, rd_en}, 0);
      chk_pins("gap_nop", 4);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      wr_sdram_en = 1;
      #2 rst = 1;
      tick();
      tick();
      chk("rst_en", {aref_en, wr_en, rd_en}, 0);
      chk_pins("rst_pins", 0);
      chk("rst_cke", cke, 1);
      chk("rst_dq", dq, 16'hFFFF);
      rst = 0;
      wr_sdram_en = 0;
      for (int c = 1; c < 20; c++) begin
         #1 chk_pins("init_hold", 0);
         tick();
      end
      init_end = 1;
      #1 chk_pins("init_last", 0);
      tick();
      init_end = 0;
      #1 chk_pins("arbit_nop", 4);
      chk("arbit_en", {aref_en, wr_en, rd_en}, 0);
      tick();
      chk_pins("init_end_drop", 4);
      // all three at once: refresh, then write, then read
      q.push_back(1); q.push_back(2); q.push_back(3);
      aref_req = 1; wr_req = 1; rd_req = 1;
      wait_grant(1, 1);
      aref_req = 0;
      run_txn(1, 3, -1);
      wait_grant(2, 1);
      wr_req = 0;
      run_txn(2, 4, -1);
      wait_grant(3, 1);
      rd_req = 0;
      run_txn(3, 4, -1);
      // both held: W, R, W, R
      q.push_back(2); q.push_back(3); q.push_back(2); q.push_back(3);
      wr_req = 1; rd_req = 1;
      for (int n = 0; n < 4; n++) begin
         wait_grant(n % 2 == 1 ? 3 : 2, 1);
         if (n == 3) begin
            wr_req = 0;
            rd_req = 0;
         end
         run_txn(n % 2 == 1 ? 3 : 2, 3, -1);
      end
      // single write burst, data 0..9
      q.push_back(2);
      wr_req = 1;
      wait_grant(2, 1);
      wr_req = 0;
      run_txn(2, 10, -1);
      // refresh raised mid-write waits for wr_end
      q.push_back(2); q.push_back(1);
      wr_req = 1;
      wait_grant(2, 1);
      wr_req = 0;
      run_txn(2, 5, 2);
      wait_grant(1, 1);
      aref_req = 0;
      run_txn(1, 2, -1);
      // last grant was write, so a contest now goes to read
      q.push_back(3); q.push_back(2);
      wr_req = 1; rd_req = 1;
      wait_grant(3, 1);
      rd_req = 0;
      run_txn(3, 2, -1);
      wait_grant(2, 1);
      wr_req = 0;
      run_txn(2, 2, -1);
      // reset in the middle of a read
      q.push_back(3);
      rd_req = 1;
      wait_grant(3, 1);
      rd_req = 0;
      wr_sdram_en = 1;
      tick();
      tick();
      rst = 1;
      #1;
      chk("rst_async_rd_en", {aref_en, wr_en, rd_en}, 0);
      chk_pins("rst_async_pins", 0);
      chk("rst_async_dq", dq, 16'hFFFF);
      tick();
      wr_req = 1; rd_req = 1;
      rst = 0;
      tick();
      tick();
      chk("init_ignores_req", {aref_en, wr_en, rd_en}, 0);
      chk_pins("reinit_pins", 0);
      q.push_back(2); q.push_back(3);
      init_end = 1;
      tick();
      init_end = 0;
      #1 chk_pins("reinit_nop", 4);
      wait_grant(2, 1);
      wr_req = 0;
      run_txn(2, 2, -1);
      wait_grant(3, 1);
      rd_req = 0;
      run_txn(3, 2, -1);
      repeat (3) tick();
      chk("sb_drain", q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
